count_seq_checker: RTL and testbench

- Downstream monitor for the 4-bit up counter; samples the counter's `q` every clock and checks that it steps legally (+1 modulo 2^WIDTH, or holds).
- Counts wrap-arounds (MAX->0) as a cascaded high-order count and flags illegal steps.
- Sits between the counter and the waveform/debug logic; gives a self-checking point for counter regressions.

---
 rtl/count_chk_pkg.sv | 13 +
 rtl/count_seq_checker_if.sv | 29 ++
 rtl/sat_counter.sv | 22 ++
 rtl/count_seq_checker.sv | 90 +++++++++
 tb/tb_count_seq_checker.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_chk_pkg.sv
// Shared definitions for the counter sequence checker: FSM encoding and default widths.
package count_chk_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_WRAP_W = 8;

    typedef enum logic [1:0] {
        ST_SEED  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } chk_state_e;

endpackage

// File: rtl/count_seq_checker_if.sv
// Sample stream from the monitored counter plus the checker's status outputs.
interface count_seq_checker_if
    import count_chk_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WRAP_W = DEF_WRAP_W
) ();

    logic              en;
    logic              resync;
    logic [WIDTH-1:0]  q_in;
    logic              clr_err;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              err;
    logic [WRAP_W-1:0] err_count;
    logic [1:0]        state;

    modport master (
        output en, resync, q_in, clr_err,
        input  wrap_pulse, wrap_count, err, err_count, state
    );

    modport slave (
        input  en, resync, q_in, clr_err,
        output wrap_pulse, wrap_count, err, err_count, state
    );

endinterface

// File: rtl/sat_counter.sv
// Unsigned event counter with synchronous clear; optionally sticks at all-ones.
// Latency: count reflects inc one clock after the edge that samples it.
// Backpressure: none; clr has priority over inc.
module sat_counter #(
    parameter int W   = 8,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && !(SAT && (&count))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// Monitors an up counter's samples for legal +1/hold steps, counting wraps and illegal steps.
// Latency: every status output is registered, one clock after the sampled edge.
// Backpressure: none; samples are consumed whenever en=1, resync re-seeds the reference.
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int WRAP_W     = DEF_WRAP_W,
    parameter bit ALLOW_HOLD = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    count_seq_checker_if.slave   bus
);

    chk_state_e        st_q;
    logic [WIDTH-1:0]  prev_q;
    logic              wrap_pulse_q;
    logic              err_q;
    logic [WRAP_W-1:0] wrap_count_w;
    logic [WRAP_W-1:0] err_count_w;

    logic [WIDTH-1:0]  prev_inc;
    logic              sample;
    logic              is_step;
    logic              is_hold;
    logic              illegal;
    logic              wrap_inc;

    // A sample is only judged once a reference exists and no re-seed is pending.
    assign prev_inc = prev_q + WIDTH'(1);
    assign sample   = bus.en && !bus.resync && (st_q != ST_SEED);
    assign is_step  = (bus.q_in == prev_inc);
    assign is_hold  = ALLOW_HOLD && (bus.q_in == prev_q);
    assign illegal  = sample && !is_step && !is_hold;
    assign wrap_inc = sample && is_step && (prev_q == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q         <= ST_SEED;
            prev_q       <= '0;
            wrap_pulse_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wrap_pulse_q <= wrap_inc;
            if (bus.resync) begin
                st_q <= ST_SEED;
            end else if (st_q == ST_SEED) begin
                if (bus.en) begin
                    prev_q <= bus.q_in;
                    st_q   <= ST_TRACK;
                end
            end else if (illegal) begin
                // An illegal step outranks a simultaneous clr_err.
                err_q  <= 1'b1;
                prev_q <= bus.q_in;
                st_q   <= ST_ERROR;
            end else begin
                if (sample && is_step) begin
                    prev_q <= bus.q_in;
                end
                if (bus.clr_err) begin
                    err_q <= 1'b0;
                    st_q  <= ST_TRACK;
                end
            end
        end
    end

    sat_counter #(.W(WRAP_W), .SAT(1'b0)) u_wrap_cnt (
        .clk   (clk),
        .clr   (!reset),
        .inc   (wrap_inc),
        .count (wrap_count_w)
    );

    sat_counter #(.W(WRAP_W), .SAT(1'b1)) u_err_cnt (
        .clk   (clk),
        .clr   (!reset),
        .inc   (illegal),
        .count (err_count_w)
    );

    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.wrap_count = wrap_count_w;
    assign bus.err        = err_q;
    assign bus.err_count  = err_count_w;
    assign bus.state      = st_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: one DUT allows holds (index 0), one does not (index 1).
module tb_count_seq_checker;
    import count_chk_pkg::*;

    localparam int W  = 4;
    localparam int WW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    count_seq_checker_if #(.WIDTH(W), .WRAP_W(WW)) bh ();
    count_seq_checker_if #(.WIDTH(W), .WRAP_W(WW)) bn ();

    count_seq_checker #(.WIDTH(W), .WRAP_W(WW), .ALLOW_HOLD(1'b1)) dut_h (
        .clk(clk), .reset(reset), .bus(bh.slave));
    count_seq_checker #(.WIDTH(W), .WRAP_W(WW), .ALLOW_HOLD(1'b0)) dut_n (
        .clk(clk), .reset(reset), .bus(bn.slave));

    int total = 0;
    int bad   = 0;

    logic          o_pulse [2];
    logic          o_err   [2];
    logic [WW-1:0] o_wc    [2];
    logic [WW-1:0] o_ec    [2];
    logic [1:0]    o_st    [2];

    assign o_pulse[0] = bh.wrap_pulse;  assign o_pulse[1] = bn.wrap_pulse;
    assign o_err[0]   = bh.err;         assign o_err[1]   = bn.err;
    assign o_wc[0]    = bh.wrap_count;  assign o_wc[1]    = bn.wrap_count;
    assign o_ec[0]    = bh.err_count;   assign o_ec[1]    = bn.err_count;
    assign o_st[0]    = bh.state;       assign o_st[1]    = bn.state;

    // Reference model: state as 0 seed / 1 track / 2 error, counts as plain integers.
    int m_st [2], m_prev [2], m_wc [2], m_ec [2];
    bit m_err [2], m_pulse [2];

    task automatic model(input bit rst_n_v, input bit en_v, input bit rs_v, input int q, input bit clr_v);
        for (int k = 0; k < 2; k++) begin
            bit hold_ok = (k == 0);
            bit ill = 1'b0;
            if (!rst_n_v) begin
                m_st[k] = 0; m_prev[k] = 0; m_wc[k] = 0; m_ec[k] = 0;
                m_err[k] = 1'b0; m_pulse[k] = 1'b0;
            end else begin
                m_pulse[k] = 1'b0;
                if (rs_v) begin
                    m_st[k] = 0;
                end else if (m_st[k] == 0) begin
                    if (en_v) begin
                        m_prev[k] = q;
                        m_st[k]   = 1;
                    end
                end else begin
                    if (en_v) begin
                        if (q == (m_prev[k] + 1) % 16) begin
                            if (m_prev[k] == 15) begin
                                m_wc[k]    = (m_wc[k] + 1) % 256;
                                m_pulse[k] = 1'b1;
                            end
                            m_prev[k] = q;
                        end else if (!(hold_ok && q == m_prev[k])) begin
                            ill       = 1'b1;
                            m_err[k]  = 1'b1;
                            m_ec[k]   = (m_ec[k] < 255) ? m_ec[k] + 1 : 255;
                            m_prev[k] = q;
                            m_st[k]   = 2;
                        end
                    end
                    if (!ill && clr_v) begin
                        m_err[k] = 1'b0;
                        m_st[k]  = 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit rst_n_v, input bit en_v, input bit rs_v, input int q, input bit clr_v);
        reset      = rst_n_v;
        bh.en      = en_v;  bn.en      = en_v;
        bh.resync  = rs_v;  bn.resync  = rs_v;
        bh.clr_err = clr_v; bn.clr_err = clr_v;
        bh.q_in    = 4'(q); bn.q_in    = 4'(q);
        @(posedge clk);
        model(rst_n_v, en_v, rs_v, q, clr_v);
        @(negedge clk);
    endtask

    task automatic feed(input int q);
        step(1'b1, 1'b1, 1'b0, q, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 7, 1'b1);
        for (int k = 0; k < 2; k++) begin
            total++; if (o_st[k] !== 2'd0) begin bad++; $display("FAIL reset_state dut%0d got=%0d exp=0", k, o_st[k]); end
            total++; if (o_pulse[k] !== 1'b0) begin bad++; $display("FAIL reset_pulse dut%0d got=%0b exp=0", k, o_pulse[k]); end
            total++; if (o_wc[k] !== 8'd0) begin bad++; $display("FAIL reset_wrapcnt dut%0d got=%0d exp=0", k, o_wc[k]); end
            total++; if (o_ec[k] !== 8'd0) begin bad++; $display("FAIL reset_errcnt dut%0d got=%0d exp=0", k, o_ec[k]); end
            total++; if (o_err[k] !== 1'b0) begin bad++; $display("FAIL reset_err dut%0d got=%0b exp=0", k, o_err[k]); end
        end
    endtask

    task automatic test_count_wrap();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            feed(i % 16);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (o_pulse[k] !== (i == 16)) begin
                    bad++; $display("FAIL wrap_pulse dut%0d sample=%0d got=%0b exp=%0b", k, i, o_pulse[k], (i == 16));
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            total++; if (o_wc[k] !== 8'd1) begin bad++; $display("FAIL wrap_count dut%0d got=%0d exp=1", k, o_wc[k]); end
            total++; if (o_err[k] !== 1'b0) begin bad++; $display("FAIL wrap_err dut%0d got=%0b exp=0", k, o_err[k]); end
            total++; if (o_st[k] !== 2'd1) begin bad++; $display("FAIL wrap_state dut%0d got=%0d exp=1", k, o_st[k]); end
        end
    endtask

    task automatic test_illegal_clr();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        feed(5);
        feed(7);
        for (int k = 0; k < 2; k++) begin
            total++; if (o_err[k] !== 1'b1 || o_ec[k] !== 8'd1 || o_st[k] !== 2'd2) begin
                bad++; $display("FAIL skip_detect dut%0d got err=%0b cnt=%0d st=%0d exp 1/1/2", k, o_err[k], o_ec[k], o_st[k]);
            end
        end
        feed(8);
        for (int k = 0; k < 2; k++) begin
            total++; if (o_err[k] !== 1'b1 || o_ec[k] !== 8'd1 || o_st[k] !== 2'd2) begin
                bad++; $display("FAIL error_track dut%0d got err=%0b cnt=%0d st=%0d exp 1/1/2", k, o_err[k], o_ec[k], o_st[k]);
            end
        end
        step(1'b1, 1'b0, 1'b0, 8, 1'b1);
        for (int k = 0; k < 2; k++) begin
            total++; if (o_err[k] !== 1'b0 || o_ec[k] !== 8'd1 || o_st[k] !== 2'd1) begin
                bad++; $display("FAIL clr_err dut%0d got err=%0b cnt=%0d st=%0d exp 0/1/1", k, o_err[k], o_ec[k], o_st[k]);
            end
        end
        // Illegal step in the same cycle as clr_err: the error must win.
        step(1'b1, 1'b1, 1'b0, 3, 1'b1);
        for (int k = 0; k < 2; k++) begin
            total++; if (o_err[k] !== 1'b1 || o_ec[k] !== 8'd2 || o_st[k] !== 2'd2) begin
                bad++; $display("FAIL clr_vs_illegal dut%0d got err=%0b cnt=%0d st=%0d exp 1/2/2", k, o_err[k], o_ec[k], o_st[k]);
            end
        end
    endtask

    task automatic test_hold();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        feed(9);
        feed(9);
        for (int k = 0; k < 2; k++) begin
            bit exp_e = (k == 1);
            total++; if (o_err[k] !== exp_e || o_ec[k] !== 8'(exp_e)) begin
                bad++; $display("FAIL hold dut%0d got err=%0b cnt=%0d exp err=%0b cnt=%0d", k, o_err[k], o_ec[k], exp_e, exp_e);
            end
        end
    endtask

    task automatic test_resync();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        feed(14);
        feed(15);
        for (int q = 0; q <= 10; q++) feed(q);
        step(1'b1, 1'b1, 1'b1, 11, 1'b0);
        for (int k = 0; k < 2; k++) begin
            total++; if (o_st[k] !== 2'd0 || o_wc[k] !== 8'd1) begin
                bad++; $display("FAIL resync_seed dut%0d got st=%0d wc=%0d exp 0/1", k, o_st[k], o_wc[k]);
            end
        end
        feed(0); feed(1); feed(2);
        for (int k = 0; k < 2; k++) begin
            total++; if (o_st[k] !== 2'd1 || o_err[k] !== 1'b0 || o_wc[k] !== 8'd1 || o_ec[k] !== 8'd0) begin
                bad++; $display("FAIL resync_track dut%0d got st=%0d err=%0b wc=%0d ec=%0d exp 1/0/1/0", k, o_st[k], o_err[k], o_wc[k], o_ec[k]);
            end
        end
    endtask

    task automatic test_reset_in_error();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        feed(0); feed(5); feed(9); feed(1);
        for (int k = 0; k < 2; k++) begin
            total++; if (o_ec[k] !== 8'd3 || o_st[k] !== 2'd2 || o_err[k] !== 1'b1) begin
                bad++; $display("FAIL pre_reset dut%0d got ec=%0d st=%0d err=%0b exp 3/2/1", k, o_ec[k], o_st[k], o_err[k]);
            end
        end
        step(1'b0, 1'b1, 1'b0, 2, 1'b1);
        for (int k = 0; k < 2; k++) begin
            total++; if (o_ec[k] !== 8'd0 || o_st[k] !== 2'd0 || o_err[k] !== 1'b0 || o_wc[k] !== 8'd0 || o_pulse[k] !== 1'b0) begin
                bad++; $display("FAIL reset_override dut%0d got ec=%0d st=%0d err=%0b wc=%0d exp all 0", k, o_ec[k], o_st[k], o_err[k], o_wc[k]);
            end
        end
    endtask

    task automatic test_saturate();
        int pulses;
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        feed(0);
        for (int i = 1; i <= 300; i++) feed((2 * i) % 16);
        for (int k = 0; k < 2; k++) begin
            total++; if (o_ec[k] !== 8'd255 || o_err[k] !== 1'b1 || o_wc[k] !== 8'd0) begin
                bad++; $display("FAIL err_saturate dut%0d got ec=%0d err=%0b wc=%0d exp 255/1/0", k, o_ec[k], o_err[k], o_wc[k]);
            end
        end
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        feed(0);
        pulses = 0;
        for (int i = 1; i <= 260 * 16; i++) begin
            feed(i % 16);
            if (o_pulse[0] === 1'b1) pulses++;
        end
        total++; if (pulses != 260) begin bad++; $display("FAIL pulse_total got=%0d exp=260", pulses); end
        for (int k = 0; k < 2; k++) begin
            total++; if (o_wc[k] !== 8'd4 || o_ec[k] !== 8'd0) begin
                bad++; $display("FAIL wrap_modulo dut%0d got wc=%0d ec=%0d exp 4/0", k, o_wc[k], o_ec[k]);
            end
        end
    endtask

    task automatic test_random();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            bit rst_n_v = ($urandom_range(0, 99) != 0);
            bit en_v    = ($urandom_range(0, 9) < 8);
            bit rs_v    = ($urandom_range(0, 29) == 0);
            bit clr_v   = ($urandom_range(0, 19) == 0);
            int r       = int'($urandom_range(0, 9));
            int q;
            if (r < 6)      q = (m_prev[0] + 1) % 16;
            else if (r < 8) q = m_prev[0];
            else            q = int'($urandom_range(0, 15));
            step(rst_n_v, en_v, rs_v, q, clr_v);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (o_st[k] !== 2'(m_st[k]) || o_err[k] !== m_err[k] || o_pulse[k] !== m_pulse[k] ||
                    o_wc[k] !== 8'(m_wc[k]) || o_ec[k] !== 8'(m_ec[k])) begin
                    bad++;
                    $display("FAIL random dut%0d cyc=%0d got st=%0d err=%0b p=%0b wc=%0d ec=%0d exp st=%0d err=%0b p=%0b wc=%0d ec=%0d",
                             k, n, o_st[k], o_err[k], o_pulse[k], o_wc[k], o_ec[k],
                             m_st[k], m_err[k], m_pulse[k], m_wc[k], m_ec[k]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bh.en = 1'b0; bh.resync = 1'b0; bh.clr_err = 1'b0; bh.q_in = '0;
        bn.en = 1'b0; bn.resync = 1'b0; bn.clr_err = 1'b0; bn.q_in = '0;
        test_reset();
        test_count_wrap();
        test_illegal_clr();
        test_hold();
        test_resync();
        test_reset_in_error();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
